// File: rtl/vga_host_bridge.sv
// vga_host_bridge
//
// CPU-side initiator for the VGA text controller's MCU port. CPU VRAM writes
// are queued in a small FIFO and replayed onto the controller's port only
// while the controller reports blank, so VRAM traffic never competes with the
// video address generator during active display. CPU reads are run the same
// way, and only once every queued write has been drained.
//
// Ports
//   pclk, rst_n     pixel clock, asynchronous active-low reset
//   cpu_addr        CPU VRAM address (stable while its strobe is low)
//   cpu_wdata       CPU write data (stable while cpu_wr_n is low)
//   cpu_rdata       registered read data returned to the CPU
//   cpu_cs_n        VRAM window select (asynchronous to pclk)
//   cpu_wr_n        CPU write strobe
//   cpu_rd_n        CPU read strobe
//   cpu_wait_n      CPU wait request, active low, combinational
//   blank           blank output of the vga block; gates access start
//   v_addr          address to the vga block
//   v_data          bidirectional data to the vga block
//   v_cs_n, v_wr_n, v_rd_n   strobes to the vga block
//   fifo_level      current write FIFO occupancy
//   ovf             sticky: a write was lost because the FIFO stayed full

module vga_host_bridge #(
  parameter int FIFO_DEPTH = 4,
  parameter int WR_PULSE   = 2,
  parameter int RD_SETTLE  = 2
) (
  input  logic                        pclk,
  input  logic                        rst_n,
  input  logic [13:0]                 cpu_addr,
  input  logic [7:0]                  cpu_wdata,
  output logic [7:0]                  cpu_rdata,
  input  logic                        cpu_cs_n,
  input  logic                        cpu_wr_n,
  input  logic                        cpu_rd_n,
  output logic                        cpu_wait_n,
  input  logic                        blank,
  output logic [13:0]                 v_addr,
  inout  wire  [7:0]                  v_data,
  output logic                        v_cs_n,
  output logic                        v_wr_n,
  output logic                        v_rd_n,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        ovf
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH  = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0] WR_LAST = 8'(WR_PULSE - 1);
  localparam logic [7:0] RD_LAST = 8'(RD_SETTLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    RD_STROBE,
    RD_SAMPLE
  } state_t;

  state_t state, state_next;

  logic       wr_req, rd_req;
  logic       wr_meta, wr_sync, wr_prev;
  logic       rd_meta, rd_sync;
  logic       wr_rise, wr_want, wr_pend;
  logic       push, pop, drop;
  logic       full, empty;
  logic       rd_done;
  logic       v_oe;
  logic [7:0] v_wdata;
  logic [7:0] cnt;

  logic [13:0]   fifo_addr [FIFO_DEPTH];
  logic [7:0]    fifo_data [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  assign wr_req = ~cpu_cs_n & ~cpu_wr_n;
  assign rd_req = ~cpu_cs_n & ~cpu_rd_n;

  // CPU strobes are asynchronous to pclk; wr_prev adds the edge-detect stage.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_meta <= 1'b0;
      wr_sync <= 1'b0;
      wr_prev <= 1'b0;
      rd_meta <= 1'b0;
      rd_sync <= 1'b0;
    end else begin
      wr_meta <= wr_req;
      wr_sync <= wr_meta;
      wr_prev <= wr_sync;
      rd_meta <= rd_req;
      rd_sync <= rd_meta;
    end
  end

  // A write that finds the FIFO full stays pending while the CPU is held in
  // wait; it is pushed as soon as a slot frees. If the CPU ends the strobe
  // anyway (ignoring wait), the write is lost and ovf latches.
  assign wr_rise = wr_sync & ~wr_prev;
  assign wr_want = wr_rise | wr_pend;
  assign push    = wr_want & wr_sync & ~full;
  assign drop    = wr_pend & ~wr_sync;
  assign pop     = (state == WR_HOLD);

  assign full       = (count == DEPTH);
  assign empty      = (count == '0);
  assign fifo_level = count;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pend <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (push || drop) begin
        wr_pend <= 1'b0;
      end else if (wr_want) begin
        wr_pend <= 1'b1;
      end
      if (drop) begin
        ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge pclk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= cpu_addr;
      fifo_data[wr_ptr] <= cpu_wdata;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // blank only gates the start of an access; once started it runs to the end.
  // Reads require an empty FIFO so they always observe earlier writes.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (blank && !empty) begin
          state_next = WR_SETUP;
        end else if (blank && rd_sync && !rd_done) begin
          state_next = RD_STROBE;
        end
      end
      WR_SETUP:  state_next = WR_STROBE;
      WR_STROBE: if (cnt == WR_LAST) state_next = WR_HOLD;
      WR_HOLD:   state_next = IDLE;
      RD_STROBE: if (cnt == RD_LAST) state_next = RD_SAMPLE;
      RD_SAMPLE: state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Cycle counter within the current state, restarted on every transition.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state_next != state) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  // Port outputs are registered from the next state so the vga block sees
  // glitch-free strobes that change together with the state register.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      v_cs_n  <= 1'b1;
      v_wr_n  <= 1'b1;
      v_rd_n  <= 1'b1;
      v_oe    <= 1'b0;
      v_addr  <= '0;
      v_wdata <= '0;
    end else begin
      v_cs_n <= (state_next == IDLE);
      v_wr_n <= (state_next != WR_STROBE);
      v_rd_n <= !((state_next == RD_STROBE) || (state_next == RD_SAMPLE));
      v_oe   <= (state_next == WR_SETUP) || (state_next == WR_STROBE) ||
                (state_next == WR_HOLD);
      if (state == IDLE && state_next == WR_SETUP) begin
        v_addr  <= fifo_addr[rd_ptr];
        v_wdata <= fifo_data[rd_ptr];
      end else if (state == IDLE && state_next == RD_STROBE) begin
        v_addr <= cpu_addr;
      end
    end
  end

  assign v_data = v_oe ? v_wdata : 8'hzz;

  // rd_done keeps a completed read from being re-run while the CPU still
  // holds its strobe; it clears once the synchronised strobe goes away.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata <= '0;
      rd_done   <= 1'b0;
    end else if (state == RD_SAMPLE) begin
      cpu_rdata <= v_data;
      rd_done   <= 1'b1;
    end else if (!rd_sync) begin
      rd_done <= 1'b0;
    end
  end

  assign cpu_wait_n = ~((wr_req & full) | (rd_req & ~rd_done));

endmodule
